// File: rtl/sram_pattern_player.sv
// Plays a byte sequence from a shared 64x8 SRAM onto PAT at a programmable
// byte period, or records pin_in into the SRAM at the same cadence.
module sram_pattern_player (
  input  logic        wb_clk_i,
  input  logic        rst_n,
  input  logic [31:0] custom_settings,
  input  logic [7:0]  pin_in,
  output logic [5:0]  sram_addr,
  output logic [7:0]  sram_in,
  output logic        sram_gwe,
  input  logic [7:0]  sram_out,
  output logic [16:0] design_do,
  output logic [16:0] design_oeb
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_FETCH,
    S_HOLD,
    S_DONE
  } state_t;

  state_t      state, state_nx;
  logic [5:0]  ptr, ptr_nx;
  logic [15:0] cnt, cnt_nx;
  logic [7:0]  pat, pat_nx;

  logic [5:0]  end_q;
  logic [15:0] div_q;
  logic        loop_q;
  logic        rec_q;

  logic        en_prev;
  logic        armed;
  logic        en;
  logic        start;
  logic        latch;
  logic        busy;
  logic        done;
  logic        strobe;
  logic        gwe;
  logic        unused_cfg;

  assign en         = custom_settings[23];
  assign unused_cfg = ^custom_settings[31:25];

  // armed stays low until EN has been seen low after reset, so an EN that is
  // already high when reset releases cannot masquerade as a rising edge.
  assign start = en & ~en_prev & armed;

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      ptr     <= '0;
      cnt     <= '0;
      pat     <= '0;
      end_q   <= '0;
      div_q   <= '0;
      loop_q  <= 1'b0;
      rec_q   <= 1'b0;
      en_prev <= 1'b0;
      armed   <= 1'b0;
    end else begin
      state   <= state_nx;
      ptr     <= ptr_nx;
      cnt     <= cnt_nx;
      pat     <= pat_nx;
      en_prev <= en;
      armed   <= armed | ~en;
      if (latch) begin
        end_q  <= custom_settings[5:0];
        div_q  <= custom_settings[21:6];
        loop_q <= custom_settings[22];
        rec_q  <= custom_settings[24];
      end
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    cnt_nx   = cnt;
    pat_nx   = pat;
    latch    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    strobe   = 1'b0;
    gwe      = 1'b0;

    // EN low overrides every state: outputs drop now, IDLE on the next edge.
    if (!en) begin
      state_nx = S_IDLE;
      ptr_nx   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          ptr_nx = '0;
          if (start) begin
            state_nx = S_ADDR;
            latch    = 1'b1;
          end
        end
        S_ADDR: begin
          busy     = 1'b1;
          gwe      = rec_q;
          state_nx = S_FETCH;
        end
        S_FETCH: begin
          busy     = 1'b1;
          strobe   = 1'b1;
          pat_nx   = rec_q ? pin_in : sram_out;
          cnt_nx   = '0;
          state_nx = S_HOLD;
        end
        S_HOLD: begin
          busy = 1'b1;
          if (cnt == div_q) begin
            if (ptr == end_q) begin
              if (loop_q) begin
                ptr_nx   = '0;
                state_nx = S_ADDR;
              end else begin
                state_nx = S_DONE;
              end
            end else begin
              ptr_nx   = ptr + 6'd1;
              state_nx = S_ADDR;
            end
          end else begin
            cnt_nx = cnt + 16'd1;
          end
        end
        S_DONE: begin
          done = 1'b1;
        end
        default: begin
          state_nx = S_IDLE;
          ptr_nx   = '0;
        end
      endcase
    end
  end

  assign sram_addr  = ptr;
  assign sram_gwe   = gwe;
  assign sram_in    = gwe ? pin_in : '0;
  assign design_do  = {strobe, done, busy, ptr, pat};
  assign design_oeb = {9'b0, {8{rec_q}}};

endmodule

// File: tb/tb_sram_pattern_player.sv
// Bench for sram_pattern_player: a time-indexed model of the byte schedule
// is compared against the DUT every cycle, plus literal scenario checks.
module tb_sram_pattern_player;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] custom_settings = '0;
  logic [7:0]  pin_in = '0;
  logic [5:0]  sram_addr;
  logic [7:0]  sram_in;
  logic        sram_gwe;
  logic [7:0]  sram_out;
  logic [16:0] design_do;
  logic [16:0] design_oeb;

  always #5 clk = ~clk;

  sram_pattern_player dut (
    .wb_clk_i       (clk),
    .rst_n          (rst_n),
    .custom_settings(custom_settings),
    .pin_in         (pin_in),
    .sram_addr      (sram_addr),
    .sram_in        (sram_in),
    .sram_gwe       (sram_gwe),
    .sram_out       (sram_out),
    .design_do      (design_do),
    .design_oeb     (design_oeb)
  );

  // 64x8 SRAM with registered read; preload port used only while in reset
  logic [7:0] sram_mem [64];
  logic [7:0] sram_q;
  logic       pl_we = 1'b0;
  logic [5:0] pl_addr = '0;
  logic [7:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_we) sram_mem[pl_addr] <= pl_data;
    else if (sram_gwe) sram_mem[sram_addr] <= sram_in;
    sram_q <= sram_mem[sram_addr];
  end
  assign sram_out = sram_q;

  int checks = 0;
  int failures = 0;

  // Model: a run is described by the number of cycles t since its first
  // address cycle; byte k = t / period occupies phase t % period.
  logic [7:0]  exp_mem [64];
  bit          m_running, m_done, m_en_prev, m_armed, m_loop, m_rec;
  int          m_t, m_end, m_div;
  logic [7:0]  m_pat;
  logic [31:0] m_cs = '0;
  logic [7:0]  m_pin = '0;

  logic [7:0]  q_pat [$];
  int          q_str [$];
  logic [5:0]  q_gwe [$];
  bit          last_str = 1'b0;
  int          cyc = 0;

  logic [7:0]  e35 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0]  e37 [3] = '{8'hA0, 8'hA1, 8'hA2};

  function automatic int period();
    return m_div + 3;
  endfunction

  function automatic int byte_addr(int k);
    return m_loop ? k % (m_end + 1) : k;
  endfunction

  function automatic logic [31:0] cfg(int ea, int dv, bit lp, bit en, bit rc);
    logic [31:0] c;
    c = '0;
    c[5:0]  = 6'(ea);
    c[21:6] = 16'(dv);
    c[22]   = lp;
    c[23]   = en;
    c[24]   = rc;
    return c;
  endfunction

  task automatic model_reset();
    m_running = 0; m_done = 0; m_en_prev = 0; m_armed = 0;
    m_t = 0; m_end = 0; m_div = 0; m_loop = 0; m_rec = 0; m_pat = '0;
  endtask

  task automatic model_edge();
    int p, k, o, a;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (!m_cs[23]) begin
      m_running = 0;
      m_done = 0;
    end else if (m_running) begin
      p = period(); k = m_t / p; o = m_t % p; a = byte_addr(k);
      if (o == 0 && m_rec) exp_mem[a] = m_pin;
      if (o == 1) m_pat = m_rec ? m_pin : exp_mem[a];
      m_t++;
      if (!m_loop && m_t == (m_end + 1) * p) begin
        m_running = 0;
        m_done = 1;
      end
    end else if (!m_done && !m_en_prev && m_armed) begin
      m_running = 1; m_t = 0;
      m_end = int'(m_cs[5:0]); m_div = int'(m_cs[21:6]);
      m_loop = m_cs[22]; m_rec = m_cs[24];
    end
    m_armed = m_armed | !m_cs[23];
    m_en_prev = m_cs[23];
  endtask

  task automatic chk(input string name, input logic [16:0] act, input logic [16:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic compare();
    int p, o;
    logic [5:0] e_ptr;
    logic e_busy, e_done, e_str, e_gwe;
    p = period(); o = m_t % p;
    e_busy = m_cs[23] && m_running;
    e_done = m_cs[23] && m_done;
    e_str  = e_busy && o == 1;
    e_gwe  = e_busy && m_rec && o == 0;
    e_ptr  = m_running ? 6'(byte_addr(m_t / p)) : (m_done ? 6'(m_end) : 6'd0);
    chk("design_do", design_do, {e_str, e_done, e_busy, e_ptr, m_pat});
    chk("sram_gwe", 17'(sram_gwe), 17'(e_gwe));
    chk("design_oeb", design_oeb, m_rec ? 17'h000FF : 17'h0);
    if (e_busy && o == 0) chk("sram_addr", 17'(sram_addr), 17'(e_ptr));
    if (e_gwe) chk("sram_in", 17'(sram_in), 17'(m_pin));
  endtask

  task automatic observe();
    if (last_str) q_pat.push_back(design_do[7:0]);
    if (design_do[16]) q_str.push_back(cyc);
    if (sram_gwe) q_gwe.push_back(sram_addr);
    last_str = design_do[16];
    cyc++;
  endtask

  task automatic clear_obs();
    q_pat.delete(); q_str.delete(); q_gwe.delete();
    last_str = 0;
  endtask

  // One clock: advance the model across the edge, apply new inputs, compare.
  task automatic step(input logic en, input logic [31:0] cs, input logic [7:0] pin);
    logic [31:0] c;
    @(posedge clk); #1;
    model_edge();
    c = cs;
    c[23] = en;
    if (m_running && (m_t % period()) < 2) pin = m_pin;
    m_cs = c; m_pin = pin;
    custom_settings = c; pin_in = pin;
    #1;
    compare();
    observe();
  endtask

  initial begin
    int maxp;
    bit saw_done, saw_wrap;
    logic [5:0] prevp;
    int ea, dv, n;
    bit lp, rc, e;

    // reset + preload
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      pl_we = 1'b1; pl_addr = 6'(i);
      if (i < 4) pl_data = e35[i];
      else if (i == 5) pl_data = 8'h55;
      else pl_data = 8'($urandom());
      exp_mem[i] = pl_data;
    end
    @(negedge clk);
    pl_we = 1'b0;
    model_reset();
    chk("reset_do", design_do, 17'h0);
    chk("reset_oeb", design_oeb, 17'h0);
    chk("reset_gwe", 17'(sram_gwe), 17'h0);
    compare();
    rst_n = 1'b1;

    // basic play, no loop
    step(0, '0, 0); step(0, '0, 0);
    clear_obs(); cyc = 0;
    for (int c = 0; c < 30; c++) step(1, cfg(3, 2, 0, 1, 0), 0);
    chk("r35_strobes", 17'(q_str.size()), 17'd4);
    for (int i = 1; i < q_str.size(); i++) chk("r35_spacing", 17'(q_str[i] - q_str[i-1]), 17'd5);
    for (int i = 0; i < q_pat.size() && i < 4; i++) chk("r35_pat", 17'(q_pat[i]), 17'(e35[i]));
    chk("r35_done", 17'(design_do[15]), 17'd1);
    chk("r35_busy", 17'(design_do[14]), 17'd0);
    chk("r35_pat_final", 17'(design_do[7:0]), 17'h44);

    // loop over two addresses
    step(0, '0, 0); step(0, '0, 0);
    clear_obs(); maxp = 0; saw_done = 0;
    for (int c = 0; c < 25; c++) begin
      step(1, cfg(1, 0, 1, 1, 0), 0);
      if (int'(design_do[13:8]) > maxp) maxp = int'(design_do[13:8]);
      if (design_do[15]) saw_done = 1;
    end
    chk("r36_ptr_max", 17'(maxp), 17'd1);
    chk("r36_no_done", 17'(saw_done), 17'd0);
    for (int i = 0; i < q_pat.size(); i++) chk("r36_pat", 17'(q_pat[i]), 17'(e35[i % 2]));
    for (int i = 1; i < q_str.size(); i++) chk("r36_spacing", 17'(q_str[i] - q_str[i-1]), 17'd3);

    // drop EN mid-hold at ptr 5, then restart
    step(0, '0, 0); step(0, '0, 0);
    step(1, cfg(10, 3, 0, 1, 0), 0);
    for (int c = 0; c < 100 && !(m_running && m_t / period() == 5 && m_t % period() == 3); c++)
      step(1, cfg(10, 3, 0, 1, 0), 0);
    chk("r38_ptr5", 17'(design_do[13:8]), 17'd5);
    step(0, '0, 0);
    chk("r38_busy_drop", 17'(design_do[14]), 17'd0);
    chk("r38_pat_held", 17'(design_do[7:0]), 17'h55);
    step(0, '0, 0);
    chk("r38_idle_ptr", 17'(design_do[13:8]), 17'd0);
    chk("r38_idle_pat", 17'(design_do[7:0]), 17'h55);
    step(1, cfg(10, 3, 0, 1, 0), 0);
    step(1, cfg(10, 3, 0, 1, 0), 0);
    chk("r38_restart_busy", 17'(design_do[14]), 17'd1);
    chk("r38_restart_ptr", 17'(design_do[13:8]), 17'd0);
    step(1, cfg(10, 3, 0, 1, 0), 0);
    step(1, cfg(10, 3, 0, 1, 0), 0);
    chk("r38_restart_pat", 17'(design_do[7:0]), 17'h11);

    // record three bytes, then play them back
    step(0, '0, 8'hA0); step(0, '0, 8'hA0);
    clear_obs();
    for (int c = 0; c < 20; c++) begin
      step(1, cfg(2, 1, 0, 1, 1), 8'hA0 + 8'(m_running ? m_t / period() + 1 : 0));
      if (c == 3) chk("r37_oeb", design_oeb, 17'h000FF);
    end
    chk("r37_gwe_count", 17'(q_gwe.size()), 17'd3);
    for (int i = 0; i < q_gwe.size(); i++) chk("r37_gwe_addr", 17'(q_gwe[i]), 17'(i));
    for (int i = 0; i < 3; i++) chk("r37_mem", 17'(sram_mem[i]), 17'(e37[i]));
    step(0, '0, 0); step(0, '0, 0);
    clear_obs();
    for (int c = 0; c < 14; c++) step(1, cfg(2, 0, 0, 1, 0), 0);
    chk("r37_readback_n", 17'(q_pat.size()), 17'd3);
    for (int i = 0; i < q_pat.size() && i < 3; i++) chk("r37_readback", 17'(q_pat[i]), 17'(e37[i]));
    chk("r37_play_oeb", design_oeb, 17'h0);

    // full wrap with settings churn mid-run
    step(0, '0, 0); step(0, '0, 0);
    clear_obs(); saw_wrap = 0; prevp = '0;
    for (int c = 0; c < 220; c++) begin
      step(1, (c < 100) ? cfg(63, 0, 1, 1, 0) : cfg(5, 7, 0, 1, 1), 0);
      if (prevp == 6'd63 && design_do[13:8] == 6'd0) saw_wrap = 1;
      prevp = design_do[13:8];
    end
    chk("r40_wrap", 17'(saw_wrap), 17'd1);
    for (int i = 1; i < q_str.size(); i++) chk("r40_spacing", 17'(q_str[i] - q_str[i-1]), 17'd3);

    // randomized runs
    for (int r = 0; r < 16; r++) begin
      step(0, $urandom(), 8'($urandom())); step(0, $urandom(), 8'($urandom()));
      ea = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 5));
      dv = int'($urandom_range(0, 4));
      lp = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      step(1, cfg(ea, dv, lp, 1, rc), 8'($urandom()));
      n = int'($urandom_range(40, 120));
      for (int c = 0; c < n; c++) begin
        e = ($urandom_range(0, 49) != 0);
        step(e, $urandom(), 8'($urandom()));
      end
    end

    // async reset mid-play; EN held high through release must not start
    step(0, '0, 0); step(0, '0, 0);
    for (int c = 0; c < 8; c++) step(1, cfg(10, 1, 0, 1, 0), 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("r39_do", design_do, 17'h0);
    chk("r39_gwe", 17'(sram_gwe), 17'h0);
    chk("r39_oeb", design_oeb, 17'h0);
    chk("r39_addr", 17'(sram_addr), 17'h0);
    chk("r39_in", 17'(sram_in), 17'h0);
    compare();
    for (int c = 0; c < 3; c++) step(1, cfg(10, 1, 0, 1, 0), 0);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step(1, cfg(10, 1, 0, 1, 0), 0);
      chk("r39_no_start", 17'(design_do[14]), 17'd0);
    end
    step(0, '0, 0);
    step(1, cfg(10, 1, 0, 1, 0), 0);
    step(1, cfg(10, 1, 0, 1, 0), 0);
    chk("r39_restart", 17'(design_do[14]), 17'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
